// File: rtl/ov2640_init_seq.sv
// OV2640 init sequencer: walks the register table and issues one SCCB write per entry.
// Adds the power-up and soft-reset settle delays, NACK retries and the completion flag.
module ov2640_init_seq #(
   parameter int unsigned TABLE_LEN    = 186,
   parameter int unsigned ADDR_WIDTH   = 8,
   parameter logic [7:0]  DEVICE_ID    = 8'h60,
   parameter logic [23:0] PWRUP_CYCLES = 24'd1_000_000,
   parameter logic [23:0] SRST_CYCLES  = 24'd100_000,
   parameter int unsigned MAX_RETRY    = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  go,
   output logic [ADDR_WIDTH-1:0] rom_addr,
   input  logic [15:0]           rom_q,
   output logic                  sccb_req,
   output logic [7:0]            sccb_dev_id,
   output logic [7:0]            sccb_reg_addr,
   output logic [7:0]            sccb_wr_data,
   input  logic                  sccb_done,
   input  logic                  sccb_nack,
   output logic                  init_busy,
   output logic                  init_done,
   output logic [7:0]            err_cnt
);

   localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
   localparam logic [ADDR_WIDTH-1:0] LAST_IDX =
      (TABLE_LEN == 0) ? '0 : ADDR_WIDTH'(TABLE_LEN - 1);
   localparam logic [15:0] SRST_ENTRY = 16'h1280;

   typedef enum logic [3:0] {
      S_IDLE,
      S_PWR_WAIT,
      S_FETCH,
      S_LATCH,
      S_REQ,
      S_WAIT,
      S_SRST_WAIT,
      S_NEXT,
      S_DONE
   } state_t;

   state_t                state, state_next;
   logic [23:0]           cnt;
   logic [ADDR_WIDTH-1:0] index;
   logic [RW-1:0]         retry;
   logic                  is_srst;

   assign is_srst = ({sccb_reg_addr, sccb_wr_data} == SRST_ENTRY);

   // NOTE: every branch starts from the defaults assigned first, so no path
   // leaves state_next unassigned and no latch is inferred.
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:      if (go) state_next = S_PWR_WAIT;
         S_PWR_WAIT:  if (cnt == PWRUP_CYCLES - 24'd1)
                         state_next = (TABLE_LEN == 0) ? S_IDLE : S_FETCH;
         S_FETCH:     state_next = S_LATCH;
         S_LATCH:     state_next = S_REQ;
         S_REQ:       state_next = S_WAIT;
         S_WAIT: begin
            if (sccb_done) begin
               if (!sccb_nack)              state_next = is_srst ? S_SRST_WAIT : S_NEXT;
               else if (retry < RETRY_MAX)  state_next = S_REQ;
               else                         state_next = S_NEXT;
            end
         end
         S_SRST_WAIT: if (cnt == SRST_CYCLES - 24'd1) state_next = S_NEXT;
         S_NEXT:      state_next = (index == LAST_IDX) ? S_DONE : S_FETCH;
         S_DONE:      if (go) state_next = S_PWR_WAIT;
         default:     state_next = S_PWR_WAIT;
      endcase
   end

   // NOTE: all state updates use non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= S_PWR_WAIT;
         cnt           <= '0;
         index         <= '0;
         retry         <= '0;
         err_cnt       <= '0;
         sccb_reg_addr <= '0;
         sccb_wr_data  <= '0;
      end else begin
         state <= state_next;
         // The delay counter restarts on every state change.
         cnt   <= (state_next != state) ? '0 : cnt + 24'd1;
         case (state)
            S_PWR_WAIT: begin
               index   <= '0;
               retry   <= '0;
               err_cnt <= '0;
            end
            S_LATCH: {sccb_reg_addr, sccb_wr_data} <= rom_q;
            S_WAIT: begin
               if (sccb_done && sccb_nack) begin
                  if (retry < RETRY_MAX)     retry   <= retry + 1'b1;
                  else if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
               end
            end
            S_NEXT: begin
               retry <= '0;
               if (index != LAST_IDX) index <= index + 1'b1;
            end
            S_DONE: if (go) err_cnt <= '0;
            default: ;
         endcase
      end
   end

   assign rom_addr    = index;
   assign sccb_req    = (state == S_REQ);
   assign sccb_dev_id = DEVICE_ID;
   assign init_done   = (state == S_DONE);
   assign init_busy   = (state != S_IDLE) && (state != S_DONE);

endmodule

// File: tb/tb_ov2640_init_seq.sv
// Directed bench for ov2640_init_seq: registered table model, SCCB responder with
// programmable NACKs, and edge-accurate timing of req/done/init_done.
module tb_ov2640_init_seq;

   localparam int DONE_DLY = 20;
   localparam int BUDGET   = 3000;

   logic        clk, rst_n, go;
   logic [7:0]  rom_addr;
   logic [15:0] rom_q;
   logic        sccb_req, sccb_done, sccb_nack;
   logic [7:0]  sccb_dev_id, sccb_reg_addr, sccb_wr_data;
   logic        init_busy, init_done;
   logic [7:0]  err_cnt;

   ov2640_init_seq #(
      .TABLE_LEN   (4),
      .ADDR_WIDTH  (8),
      .DEVICE_ID   (8'h60),
      .PWRUP_CYCLES(24'd10),
      .SRST_CYCLES (24'd5),
      .MAX_RETRY   (3)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .go           (go),
      .rom_addr     (rom_addr),
      .rom_q        (rom_q),
      .sccb_req     (sccb_req),
      .sccb_dev_id  (sccb_dev_id),
      .sccb_reg_addr(sccb_reg_addr),
      .sccb_wr_data (sccb_wr_data),
      .sccb_done    (sccb_done),
      .sccb_nack    (sccb_nack),
      .init_busy    (init_busy),
      .init_done    (init_done),
      .err_cnt      (err_cnt)
   );

   logic [15:0] mem [0:255];
   logic [15:0] req_log[$];
   int          req_edge[$];
   int          done_edge[$];
   int          cyc;
   int          n_checks, n_pass;
   logic [15:0] nack_entry;
   int          nack_left;
   int          rel_cyc, rise, k;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      cyc = 0;
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   // Registered table: data for the address seen in one cycle appears in the next.
   initial begin : rom_model
      logic [7:0] a_prev;
      a_prev = '0;
      rom_q  = '0;
      forever begin
         @(negedge clk);
         rom_q  = mem[a_prev];
         a_prev = rom_addr;
      end
   end

   // SCCB responder: req seen here is taken by the master on the next edge (cyc+1);
   // done is raised DONE_DLY cycles later and sampled on the edge after that.
   initial begin : sccb_model
      int          pending;
      logic [15:0] cur;
      pending   = 0;
      cur       = '0;
      sccb_done = 1'b0;
      sccb_nack = 1'b0;
      forever begin
         @(negedge clk);
         sccb_done = 1'b0;
         sccb_nack = 1'b0;
         if (!rst_n) begin
            pending = 0;
         end else if (sccb_req) begin
            cur = {sccb_reg_addr, sccb_wr_data};
            req_log.push_back(cur);
            req_edge.push_back(cyc + 1);
            pending = DONE_DLY;
         end else if (pending > 0) begin
            pending--;
            if (pending == 0) begin
               sccb_done = 1'b1;
               if (cur == nack_entry && nack_left > 0) begin
                  sccb_nack = 1'b1;
                  nack_left--;
               end
               done_edge.push_back(cyc + 1);
            end
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
   endtask

   task automatic load_table(input logic [15:0] e0, e1, e2, e3);
      mem[0] = e0;
      mem[1] = e1;
      mem[2] = e2;
      mem[3] = e3;
   endtask

   task automatic clear_logs();
      req_log.delete();
      req_edge.delete();
      done_edge.delete();
   endtask

   task automatic release_reset();
      @(posedge clk);
      #2;
      clear_logs();
      rst_n   = 1'b1;
      rel_cyc = cyc;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      release_reset();
   endtask

   task automatic pulse_go();
      #2 go = 1'b1;
      @(posedge clk);
      #2 go = 1'b0;
   endtask

   task automatic wait_reqs(input int n, input string tag);
      int w;
      w = 0;
      while (req_log.size() < n && w < BUDGET) begin
         @(posedge clk);
         w++;
      end
      check(tag, req_log.size(), n);
   endtask

   // Returns the edge index at which init_done first went high.
   task automatic wait_done(input string tag, output int r);
      int w;
      w = 0;
      while (init_done !== 1'b1 && w < BUDGET) begin
         @(negedge clk);
         w++;
      end
      r = cyc;
      check(tag, init_done, 1);
   endtask

   initial begin
      n_checks   = 0;
      n_pass     = 0;
      rst_n      = 1'b0;
      go         = 1'b0;
      nack_entry = '0;
      nack_left  = 0;
      for (int i = 0; i < 256; i++) mem[i] = '0;
      load_table(16'h1101, 16'h2202, 16'h3303, 16'h4404);

      // Reset values
      @(negedge clk);
      check("rst_rom_addr", rom_addr, 0);
      check("rst_req", sccb_req, 0);
      check("rst_reg_addr", sccb_reg_addr, 0);
      check("rst_wr_data", sccb_wr_data, 0);
      check("rst_busy", init_busy, 1);
      check("rst_done", init_done, 0);
      check("rst_err", err_cnt, 0);
      check("rst_dev_id", sccb_dev_id, 8'h60);

      // Basic run: 10 PWR_WAIT + FETCH + LATCH + REQ -> master sees req on edge 13
      release_reset();
      wait_done("a_done", rise);
      check("a_first_req", req_edge[0] - rel_cyc, 13);
      check("a_req_count", req_log.size(), 4);
      for (int i = 0; i < 4; i++) check($sformatf("a_entry%0d", i), req_log[i], mem[i]);
      for (int i = 0; i < 3; i++) check($sformatf("a_gap%0d", i), req_edge[i+1] - done_edge[i], 4);
      check("a_done_rise", rise - done_edge[3], 1);
      check("a_err", err_cnt, 0);
      check("a_busy", init_busy, 0);

      // Soft-reset entry at index 1: 5 settle cycles added to that gap
      load_table(16'h1101, 16'h1280, 16'h3303, 16'h4404);
      do_reset();
      wait_done("b_done", rise);
      check("b_req_count", req_log.size(), 4);
      check("b_entry1", req_log[1], 16'h1280);
      check("b_gap0", req_edge[1] - done_edge[0], 4);
      check("b_gap1_srst", req_edge[2] - done_edge[1], 9);
      check("b_gap2", req_edge[3] - done_edge[2], 4);

      // Retry: entry 2 NACKed twice then ACKed
      load_table(16'h1101, 16'h2202, 16'h3303, 16'h4404);
      nack_entry = 16'h3303;
      nack_left  = 2;
      do_reset();
      wait_done("c_done", rise);
      check("c_req_count", req_log.size(), 6);
      for (int i = 2; i < 5; i++) check($sformatf("c_retry%0d", i), req_log[i], 16'h3303);
      check("c_after_retry", req_log[5], 16'h4404);
      check("c_err", err_cnt, 0);

      // Skip: entry 0 always NACKed -> 1 + 3 retries, then entry 1
      nack_entry = 16'h1101;
      nack_left  = 1000;
      do_reset();
      wait_done("d_done", rise);
      check("d_req_count", req_log.size(), 7);
      for (int i = 0; i < 4; i++) check($sformatf("d_skip%0d", i), req_log[i], 16'h1101);
      check("d_next_entry", req_log[4], 16'h2202);
      check("d_err", err_cnt, 1);
      nack_left = 0;

      // Reset while waiting on entry 2
      do_reset();
      wait_reqs(3, "e_reach_entry2");
      repeat (5) @(posedge clk);
      #2;
      check("e_rom_addr_mid", rom_addr, 2);
      check("e_req_mid", sccb_req, 0);
      rst_n = 1'b0;
      #1;
      check("e_rst_rom_addr", rom_addr, 0);
      check("e_rst_req", sccb_req, 0);
      check("e_rst_reg_addr", sccb_reg_addr, 0);
      check("e_rst_wr_data", sccb_wr_data, 0);
      check("e_rst_busy", init_busy, 1);
      check("e_rst_done", init_done, 0);
      repeat (2) @(posedge clk);
      release_reset();
      wait_done("e_done", rise);
      check("e_first_req", req_edge[0] - rel_cyc, 13);
      check("e_entry0", req_log[0], 16'h1101);
      check("e_req_count", req_log.size(), 4);

      // Go while busy is ignored; entry 3 always NACKed so DONE holds err_cnt = 1
      nack_entry = 16'h4404;
      nack_left  = 1000;
      do_reset();
      wait_reqs(2, "f_reach_entry1");
      pulse_go();
      wait_done("f_done", rise);
      check("f_req_count", req_log.size(), 7);
      check("f_entry0", req_log[0], 16'h1101);
      check("f_err", err_cnt, 1);

      // Go in DONE: init_done and err_cnt clear on the next edge, full rerun follows
      nack_left = 0;
      @(posedge clk);
      #2;
      clear_logs();
      rel_cyc = cyc;
      go = 1'b1;
      @(negedge clk);
      check("g_done_before_edge", init_done, 1);
      @(posedge clk);
      #2 go = 1'b0;
      @(negedge clk);
      check("g_done_cleared", init_done, 0);
      check("g_busy", init_busy, 1);
      check("g_err_cleared", err_cnt, 0);

      // Go in the cycle DONE is entered is ignored
      k = 0;
      while (done_edge.size() < 4 && k < BUDGET) begin
         @(posedge clk);
         k++;
      end
      check("g_reach_last_done", done_edge.size(), 4);
      pulse_go();
      wait_done("g_done", rise);
      check("g_first_req", req_edge[0] - rel_cyc, 14);
      check("g_done_rise", rise - done_edge[3], 1);
      repeat (40) @(negedge clk);
      check("g_no_restart_done", init_done, 1);
      check("g_no_restart_reqs", req_log.size(), 4);
      check("g_err_final", err_cnt, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
